// File: rtl/elevator_scheduler.sv
// Single-car collective (SCAN) scheduler: latches car and hall calls, sequences
// floor-by-floor moves and times the door dwell. All outputs decode from registers.
module elevator_scheduler #(
  parameter int unsigned FLOORS        = 6,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] btn_num_in,
  input  logic [FLOORS-1:0] btn_up_out,
  input  logic [FLOORS-1:0] btn_down_out,
  input  logic              open_btn,
  input  logic              close_btn,
  output logic              engine_up,
  output logic              engine_down,
  output logic              door,
  output logic [FLOORS-1:0] level_display,
  output logic [FLOORS-1:0] pending
);

  localparam int unsigned FW = $clog2(FLOORS);
  localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);
  localparam logic DirUp = 1'b1;

  typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [TW-1:0]     travel_q, travel_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [FLOORS-1:0] car_q, car_d;
  logic [FLOORS-1:0] up_q, up_d;
  logic [FLOORS-1:0] down_q, down_d;

  logic [FLOORS-1:0] req_all;
  logic [FW-1:0]     next_floor;
  logic              ahead, behind, press_here, at_end, stop_next, last_travel;

  // Any set bit strictly above (up=1) or strictly below (up=0) position pos.
  function automatic logic any_beyond(input logic [FLOORS-1:0] req, input logic [FW-1:0] pos,
                                      input logic up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (req[i] && (up ? (i > int'(pos)) : (i < int'(pos)))) hit = 1'b1;
    end
    return hit;
  endfunction

  assign req_all     = car_q | up_q | down_q;
  assign next_floor  = (dir_q == DirUp) ? floor_q + FW'(1) : floor_q - FW'(1);
  assign ahead       = any_beyond(req_all, floor_q, dir_q);
  assign behind      = any_beyond(req_all, floor_q, ~dir_q);
  assign press_here  = btn_num_in[floor_q] | btn_up_out[floor_q] | btn_down_out[floor_q];
  assign last_travel = (travel_q == TW'(TRAVEL_CYCLES - 1));
  // The shaft ends always stop; a furthest pending call normally guarantees this already.
  assign at_end      = (dir_q == DirUp) ? (next_floor == FW'(FLOORS - 1)) : (next_floor == '0);
  assign stop_next   = car_q[next_floor]
                     | ((dir_q == DirUp) ? up_q[next_floor] : down_q[next_floor])
                     | (~any_beyond(req_all, next_floor, dir_q) & req_all[next_floor])
                     | at_end;

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    travel_d = travel_q;
    dwell_d  = dwell_q;

    unique case (state_q)
      StIdle: begin
        if (req_all[floor_q] || open_btn) begin
          state_d = StDoor;
          dwell_d = DW'(DOOR_CYCLES);
        end else if (ahead) begin
          state_d  = StMove;
          travel_d = '0;
        end else if (behind) begin
          dir_d    = ~dir_q;
          state_d  = StMove;
          travel_d = '0;
        end
      end
      StMove: begin
        if (last_travel) begin
          floor_d  = next_floor;
          travel_d = '0;
          if (stop_next) begin
            state_d = StDoor;
            dwell_d = DW'(DOOR_CYCLES);
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end
      StDoor: begin
        // Open wins over close; a call at this floor also holds the door.
        if (press_here || open_btn) begin
          dwell_d = DW'(DOOR_CYCLES);
        end else if (close_btn || dwell_q == DW'(1)) begin
          state_d = StIdle;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    car_d  = car_q | btn_num_in;
    up_d   = up_q | btn_up_out;
    down_d = down_q | btn_down_out;
    // Serving a floor clears its calls, overriding a press in the same cycle.
    if (state_d == StDoor) begin
      car_d[floor_d]  = 1'b0;
      up_d[floor_d]   = 1'b0;
      down_d[floor_d] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      floor_q  <= '0;
      dir_q    <= DirUp;
      travel_q <= '0;
      dwell_q  <= '0;
      car_q    <= '0;
      up_q     <= '0;
      down_q   <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      travel_q <= travel_d;
      dwell_q  <= dwell_d;
      car_q    <= car_d;
      up_q     <= up_d;
      down_q   <= down_d;
    end
  end

  assign engine_up     = (state_q == StMove) && (dir_q == DirUp);
  assign engine_down   = (state_q == StMove) && (dir_q != DirUp);
  assign door          = (state_q == StDoor);
  assign level_display = {{(FLOORS-1){1'b0}}, 1'b1} << floor_q;
  assign pending       = req_all;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural model of the call/serve rules.
module tb_elevator_scheduler;

  localparam int F      = 6;
  localparam int TRAVEL = 4;
  localparam int DWELL  = 8;
  localparam int OW     = 3 + 2 * F;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [F-1:0] btn_num = '0;
  logic [F-1:0] btn_up = '0;
  logic [F-1:0] btn_down = '0;
  logic         open_b = 1'b0;
  logic         close_b = 1'b0;
  logic         engine_up, engine_down, door;
  logic [F-1:0] level_display, pending;

  int vectors = 0;
  int errors  = 0;

  // Model: mode 0 idle, 1 moving, 2 door open.
  int       ms = 0;
  int       mf = 0;
  int       mt = 0;
  int       mw = 0;
  bit       md = 1'b1;
  bit [F-1:0] mcar = '0;
  bit [F-1:0] mup = '0;
  bit [F-1:0] mdn = '0;

  elevator_scheduler #(
    .FLOORS       (F),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DWELL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_num_in   (btn_num),
    .btn_up_out   (btn_up),
    .btn_down_out (btn_down),
    .open_btn     (open_b),
    .close_btn    (close_b),
    .engine_up    (engine_up),
    .engine_down  (engine_down),
    .door         (door),
    .level_display(level_display),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  function automatic bit beyond(bit [F-1:0] v, int f, bit up);
    for (int i = 0; i < F; i++) begin
      if (v[i] && (up ? (i > f) : (i < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [OW-1:0] expected();
    logic [F-1:0] lvl;
    lvl = '0;
    lvl[mf] = 1'b1;
    return {ms == 1 && md, ms == 1 && !md, ms == 2, lvl, mcar | mup | mdn};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {engine_up, engine_down, door, level_display, pending};
  endfunction

  function automatic int floor_of(logic [F-1:0] oh);
    for (int i = 0; i < F; i++) if (oh[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic model_step();
    bit [F-1:0] pc;
    int ns, nf;
    bit nd;
    if (reset) begin
      ms = 0; mf = 0; md = 1'b1; mt = 0; mw = 0;
      mcar = '0; mup = '0; mdn = '0;
      return;
    end
    pc = mcar | mup | mdn;
    ns = ms; nf = mf; nd = md;
    case (ms)
      0: begin
        if (pc[mf] || open_b) begin ns = 2; mw = DWELL; end
        else if (beyond(pc, mf, md)) begin ns = 1; mt = 0; end
        else if (beyond(pc, mf, !md)) begin nd = !md; ns = 1; mt = 0; end
      end
      1: begin
        mt++;
        if (mt == TRAVEL) begin
          mt = 0;
          nf = md ? mf + 1 : mf - 1;
          if (mcar[nf] || (md ? mup[nf] : mdn[nf]) || (!beyond(pc, nf, md) && pc[nf])) begin
            ns = 2; mw = DWELL;
          end
        end
      end
      default: begin
        if (btn_num[mf] || btn_up[mf] || btn_down[mf] || open_b) mw = DWELL;
        else if (close_b || mw == 1) ns = 0;
        else mw--;
      end
    endcase
    mcar |= btn_num;
    mup  |= btn_up;
    mdn  |= btn_down;
    if (ns == 2) begin
      mcar[nf] = 1'b0; mup[nf] = 1'b0; mdn[nf] = 1'b0;
    end
    ms = ns; mf = nf; md = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (observed() !== {3'b000, F'(1), F'(0)}) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", observed(), {3'b000, F'(1), F'(0)});
    end
    for (int k = 0; k < 50; k++) begin
      tick();
      vectors++;
      if (observed() !== {3'b000, F'(1), F'(0)}) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", k, observed(),
                 {3'b000, F'(1), F'(0)});
      end
    end
  endtask

  task automatic test_single_call();
    int up_cnt, door_cnt;
    logic [F-1:0] prev_lvl;
    logic [F-1:0] lv[$];
    do_reset();
    btn_num = 6'b001000;
    tick();
    btn_num = '0;
    vectors++;
    if (pending !== 6'b001000) begin
      errors++;
      $display("FAIL single_pending: got %b want 001000", pending);
    end
    tick();
    vectors++;
    if (engine_up !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: engine_up got %b want 1", engine_up);
    end
    up_cnt = 1; door_cnt = 0; prev_lvl = level_display;
    for (int k = 0; k < 40; k++) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL single_model cycle %0d: got %b want %b", k, observed(), expected());
      end
      if (engine_up) up_cnt++;
      if (door) door_cnt++;
      if (level_display !== prev_lvl) begin
        lv.push_back(level_display);
        prev_lvl = level_display;
      end
    end
    vectors++;
    if (up_cnt != 12) begin
      errors++;
      $display("FAIL single_engine_cycles: got %0d want 12", up_cnt);
    end
    vectors++;
    if (door_cnt != 8) begin
      errors++;
      $display("FAIL single_door_cycles: got %0d want 8", door_cnt);
    end
    vectors++;
    if (lv.size() != 3 || lv[0] !== 6'b000010 || lv[1] !== 6'b000100 || lv[2] !== 6'b001000) begin
      errors++;
      $display("FAIL single_levels: got %0d changes want 000010,000100,001000", lv.size());
    end
    vectors++;
    if (pending !== '0 || door !== 1'b0) begin
      errors++;
      $display("FAIL single_done: pending %b door %b want 000000 0", pending, door);
    end
  endtask

  task automatic test_collective();
    int stops[$];
    int dn_cnt;
    logic prev_door;
    do_reset();
    btn_num = 6'b100000;
    tick();
    btn_num = '0;
    btn_up = 6'b000100;
    btn_down = 6'b001000;
    tick();
    btn_up = '0;
    btn_down = '0;
    dn_cnt = 0; prev_door = 1'b0;
    for (int k = 0; k < 90; k++) begin
      tick();
      vectors++;
      if (observed() !== expected() || (engine_up && engine_down)) begin
        errors++;
        $display("FAIL collective_model cycle %0d: got %b want %b", k, observed(), expected());
      end
      if (door && !prev_door) stops.push_back(floor_of(level_display));
      prev_door = door;
      if (engine_down) dn_cnt++;
    end
    vectors++;
    if (stops.size() != 3 || stops[0] != 2 || stops[1] != 5 || stops[2] != 3) begin
      errors++;
      $display("FAIL collective_stops: got %0d stops (first %0d) want 2,5,3", stops.size(),
               (stops.size() > 0) ? stops[0] : -1);
    end
    vectors++;
    if (dn_cnt != 2 * TRAVEL) begin
      errors++;
      $display("FAIL collective_down_cycles: got %0d want %0d", dn_cnt, 2 * TRAVEL);
    end
  endtask

  task automatic test_door_control();
    int cnt;
    bit ext_done;
    do_reset();
    // Plain open request from idle.
    open_b = 1'b1;
    tick();
    open_b = 1'b0;
    cnt = door ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL door_open_model cycle %0d: got %b want %b", k, observed(), expected());
      end
      if (door) cnt++;
    end
    vectors++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL door_open_cycles: got %0d want 8", cnt);
    end
    // Extend on door cycle 6.
    open_b = 1'b1;
    tick();
    open_b = 1'b0;
    cnt = door ? 1 : 0;
    ext_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      open_b = (cnt == 6 && !ext_done);
      if (open_b) ext_done = 1'b1;
      tick();
      open_b = 1'b0;
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL door_extend_model cycle %0d: got %b want %b", k, observed(), expected());
      end
      if (door) cnt++;
    end
    vectors++;
    if (cnt != 14) begin
      errors++;
      $display("FAIL door_extend_cycles: got %0d want 14", cnt);
    end
    // Close on door cycle 3.
    open_b = 1'b1;
    tick();
    open_b = 1'b0;
    cnt = door ? 1 : 0;
    for (int k = 0; k < 10 && cnt < 3; k++) begin
      tick();
      if (door) cnt++;
    end
    close_b = 1'b1;
    tick();
    close_b = 1'b0;
    vectors++;
    if (door !== 1'b0 || cnt != 3) begin
      errors++;
      $display("FAIL door_close: door %b after %0d cycles want 0 after 3", door, cnt);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL door_close_model cycle %0d: got %b want %b", k, observed(), expected());
      end
    end
  endtask

  task automatic test_simultaneous();
    int first_up, door_cnt, stop_floor;
    logic prev_door;
    do_reset();
    btn_num = 6'b010001;
    tick();
    btn_num = '0;
    vectors++;
    if (pending !== 6'b010001) begin
      errors++;
      $display("FAIL simul_pending: got %b want 010001", pending);
    end
    tick();
    vectors++;
    if (door !== 1'b1 || pending !== 6'b010000 || engine_up !== 1'b0) begin
      errors++;
      $display("FAIL simul_door_first: door %b pending %b engine_up %b want 1 010000 0", door,
               pending, engine_up);
    end
    first_up = -1; door_cnt = 1; stop_floor = -1; prev_door = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      vectors++;
      if (observed() !== expected() || (engine_up && engine_down)) begin
        errors++;
        $display("FAIL simul_model cycle %0d: got %b want %b", k, observed(), expected());
      end
      if (engine_up && first_up < 0) first_up = k;
      if (door && first_up < 0) door_cnt++;
      if (door && !prev_door) stop_floor = floor_of(level_display);
      prev_door = door;
    end
    vectors++;
    if (door_cnt != 8 || first_up != 8) begin
      errors++;
      $display("FAIL simul_sequence: door %0d cycles, move at %0d want 8 and 8", door_cnt,
               first_up);
    end
    vectors++;
    if (stop_floor != 4) begin
      errors++;
      $display("FAIL simul_stop_floor: got %0d want 4", stop_floor);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    btn_num = 6'b100000;
    tick();
    btn_num = '0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (level_display === 6'b000100 && engine_up === 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL reset_move_wait: got timeout want move past floor 2");
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (observed() !== {3'b000, F'(1), F'(0)}) begin
      errors++;
      $display("FAIL reset_in_move: got %b want %b", observed(), {3'b000, F'(1), F'(0)});
    end
    btn_num = 6'b100100;
    tick();
    btn_num = '0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (door === 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL reset_door_wait: got timeout want door open");
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (observed() !== {3'b000, F'(1), F'(0)}) begin
      errors++;
      $display("FAIL reset_in_door: got %b want %b", observed(), {3'b000, F'(1), F'(0)});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      btn_num  = ($urandom_range(0, 9) == 0) ? F'($urandom) : '0;
      btn_up   = ($urandom_range(0, 14) == 0) ? F'($urandom) : '0;
      btn_down = ($urandom_range(0, 14) == 0) ? F'($urandom) : '0;
      open_b   = ($urandom_range(0, 24) == 0);
      close_b  = ($urandom_range(0, 11) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
      vectors++;
      if (observed() !== expected() || (engine_up && engine_down)) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", k, observed(), expected());
      end
    end
    btn_num = '0; btn_up = '0; btn_down = '0;
    open_b = 1'b0; close_b = 1'b0; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_collective();
    test_door_control();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
